// File: rtl/compute_pkg.sv
// Shared types and lookup helpers for the compute engine controller.
// Op codes, per-op tile counts, op legality and the controller state encoding.
package compute_pkg;

    typedef enum logic [3:0] {
        CMP_NONE   = 4'd0,
        Q_PROJ     = 4'd1,
        K_PROJ     = 4'd2,
        V_PROJ     = 4'd3,
        ATT_SCORES = 4'd4,
        SOFTMAX    = 4'd5,
        ATT_VALUE  = 4'd6,
        OUT_PROJ   = 4'd7,
        FFN        = 4'd8,
        CONCAT     = 4'd9
    } cmp_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

    localparam logic [3:0] CMP_OP_FIRST = 4'd1;
    localparam logic [3:0] CMP_OP_LAST  = 4'd9;

    // Number of tiles each op is sequenced over; 0 for illegal codes.
    function automatic logic [7:0] cmp_tiles(input logic [3:0] op);
        logic [7:0] n;
        n = 8'd0;
        case (op)
            Q_PROJ, K_PROJ, V_PROJ, OUT_PROJ: n = 8'd4;
            ATT_SCORES:                       n = 8'd2;
            SOFTMAX:                          n = 8'd1;
            ATT_VALUE:                        n = 8'd2;
            FFN:                              n = 8'd8;
            CONCAT:                           n = 8'd1;
            default:                          n = 8'd0;
        endcase
        return n;
    endfunction

    // Low nibble legality only; the caller also checks the upper op bits are zero.
    function automatic logic cmp_op_legal(input logic [3:0] op);
        return (op >= CMP_OP_FIRST) && (op <= CMP_OP_LAST);
    endfunction

endpackage

// File: rtl/compute_engine_ctrl_tile_ctr.sv
// compute_tile_ctr: nested cycle-within-tile / tile counter.
// load starts tile 0 with a strobe; en advances one cycle; last flags the final
// cycle of the final tile. tile_idx saturates at the last tile, never wraps.
module compute_tile_ctr
    import compute_pkg::*;
#(
    parameter int TILE_LAT  = 3,
    parameter int MAX_TILES = 16
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic                          load,
    input  logic                          en,
    input  logic                          clear,
    input  logic [$clog2(MAX_TILES)-1:0]  last_tile_in,
    output logic [$clog2(MAX_TILES)-1:0]  tile_idx,
    output logic                          tile_strobe,
    output logic                          last
);

    localparam int TILE_W = $clog2(MAX_TILES);
    localparam int CYC_W  = (TILE_LAT > 1) ? $clog2(TILE_LAT) : 1;

    logic [CYC_W-1:0]  cyc;
    logic [TILE_W-1:0] last_tile;
    logic              cyc_end;
    logic              tile_end;

    assign cyc_end  = (cyc == CYC_W'(TILE_LAT - 1));
    assign tile_end = (tile_idx == last_tile);
    assign last     = cyc_end && tile_end;

    // Advance cycle and tile counters; strobe marks the first cycle of each tile.
    always_ff @(posedge ap_clk) begin
        if (ap_rst || clear) begin
            cyc         <= '0;
            tile_idx    <= '0;
            last_tile   <= '0;
            tile_strobe <= 1'b0;
        end else if (load) begin
            cyc         <= '0;
            tile_idx    <= '0;
            last_tile   <= last_tile_in;
            tile_strobe <= 1'b1;
        end else if (en) begin
            if (cyc_end) begin
                cyc <= '0;
                if (tile_end) begin
                    tile_strobe <= 1'b0;
                end else begin
                    tile_idx    <= tile_idx + 1'b1;
                    tile_strobe <= 1'b1;
                end
            end else begin
                cyc         <= cyc + 1'b1;
                tile_strobe <= 1'b0;
            end
        end else begin
            tile_strobe <= 1'b0;
        end
    end

endmodule

// File: rtl/compute_engine_ctrl.sv
// compute_engine_ctrl: responder side of the scheduler compute handshake.
// Handshake: an op is taken on a clock edge where compute_start, compute_start_ap_vld
// and compute_ready are all high; ready is low from the cycle after acceptance
// through the done cycle, so starts while busy are dropped, never queued.
// Optional feature macro: COMPUTE_PERF_CNT_EN enables saturating perf counters;
// without it the perf ports read 0 and no counter flops exist.
module compute_engine_ctrl
    import compute_pkg::*;
#(
    parameter int TILE_LAT  = 3,
    parameter int MAX_TILES = 16,
    parameter int OP_W      = 32
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic                          compute_start,
    input  logic                          compute_start_ap_vld,
    input  logic [OP_W-1:0]               compute_op,
    output logic                          compute_ready,
    output logic                          compute_done,
    output logic                          compute_err,
    output logic [3:0]                    op_active,
    output logic [$clog2(MAX_TILES)-1:0]  tile_idx,
    output logic                          tile_strobe,
    output logic [31:0]                   perf_busy_cycles,
    output logic [15:0]                   perf_op_count,
    output logic [1:0]                    dbg_state
);

    localparam int TILE_W = $clog2(MAX_TILES);

    ctrl_state_e       state;
    logic              accept;
    logic              op_legal;
    logic              ctr_load;
    logic              ctr_en;
    logic              ctr_clear;
    logic              ctr_last;
    logic [TILE_W-1:0] last_tile;

    assign accept    = compute_start && compute_start_ap_vld && compute_ready;
    assign op_legal  = (compute_op[OP_W-1:4] == '0) && cmp_op_legal(compute_op[3:0]);
    assign last_tile = TILE_W'(cmp_tiles(compute_op[3:0]) - 8'd1);
    assign ctr_load  = (state == IDLE) && accept && op_legal;
    assign ctr_en    = (state == RUN);
    assign ctr_clear = (state == DONE);
    assign dbg_state = state;

    compute_tile_ctr #(
        .TILE_LAT  (TILE_LAT),
        .MAX_TILES (MAX_TILES)
    ) u_tile_ctr (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .load         (ctr_load),
        .en           (ctr_en),
        .clear        (ctr_clear),
        .last_tile_in (last_tile),
        .tile_idx     (tile_idx),
        .tile_strobe  (tile_strobe),
        .last         (ctr_last)
    );

    // Control FSM with registered handshake outputs; illegal ops skip RUN.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state         <= IDLE;
            compute_ready <= 1'b1;
            compute_done  <= 1'b0;
            compute_err   <= 1'b0;
            op_active     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        compute_ready <= 1'b0;
                        op_active     <= compute_op[3:0];
                        if (op_legal) begin
                            state <= RUN;
                        end else begin
                            state        <= DONE;
                            compute_done <= 1'b1;
                            compute_err  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (ctr_last) begin
                        state        <= DONE;
                        compute_done <= 1'b1;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    compute_done  <= 1'b0;
                    compute_err   <= 1'b0;
                    compute_ready <= 1'b1;
                    op_active     <= 4'd0;
                end
                default: begin
                    state         <= IDLE;
                    compute_done  <= 1'b0;
                    compute_err   <= 1'b0;
                    compute_ready <= 1'b1;
                    op_active     <= 4'd0;
                end
            endcase
        end
    end

`ifdef COMPUTE_PERF_CNT_EN
    // Saturating counters: RUN cycles and completed legal ops; only reset clears them.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            perf_busy_cycles <= '0;
            perf_op_count    <= '0;
        end else if (state == RUN) begin
            if (perf_busy_cycles != '1) begin
                perf_busy_cycles <= perf_busy_cycles + 1'b1;
            end
            if (ctr_last && (perf_op_count != '1)) begin
                perf_op_count <= perf_op_count + 1'b1;
            end
        end
    end
`else
    assign perf_busy_cycles = '0;
    assign perf_op_count    = '0;
`endif

endmodule
